// File: rtl/ann_pkg.sv
// ann_pkg: shared FSM state type and default widths for the neuron datapath
package ann_pkg;
  typedef enum logic {ACC, HOLD} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
endpackage

// File: rtl/neuron_act.sv
// neuron_act: clamp the wide sum to signed DATA_W, then ReLU if NEURON_ACC_RELU_EN else identity
module neuron_act
  import ann_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] data,
  output logic              sat
);
  logic [ACC_W-DATA_W:0] hi;
  logic [DATA_W-1:0]     clamp;
  // the sum fits in DATA_W only when every bit above the DATA_W sign bit matches it
  assign hi    = sum[ACC_W-1:DATA_W-1];
  assign sat   = !((&hi) || !(|hi));
  assign clamp = sat ? {sum[ACC_W-1], {(DATA_W-1){!sum[ACC_W-1]}}} : sum[DATA_W-1:0];
`ifdef NEURON_ACC_RELU_EN
  assign data  = clamp[DATA_W-1] ? '0 : clamp;
`else
  assign data  = clamp;
`endif
endmodule

// File: rtl/neuron_acc.sv
// neuron_acc: accumulates NUM_BEATS partial products plus bias per neuron; activation set by NEURON_ACC_RELU_EN
module neuron_acc
  import ann_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int NUM_BEATS = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);
  localparam int CNT_W = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc, sum;
  logic [DATA_W-1:0] act_data;
  logic              act_sat, beat, last;
  assign in_ready  = state == ACC;
  assign out_valid = state == HOLD;
  assign beat      = in_valid && in_ready;
  assign last      = cnt == CNT_W'(NUM_BEATS - 1);
  // beat 0 restarts from the bias, so a stale acc never leaks into the next neuron
  assign sum = (cnt == '0 ? {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} : acc)
             + {{(ACC_W-DATA_W){q[DATA_W-1]}}, q};
  always_comb begin
    state_n = state;
    if (state == ACC && beat && last) state_n = HOLD;
    if (state == HOLD && out_ready) state_n = ACC;
  end
  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= ACC;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_n;
      if (beat) begin
        acc <= sum;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (beat && last) begin
        out_data <= act_data;
        out_sat  <= act_sat;
      end
    end
  end
  neuron_act #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_act (
    .sum  (sum),
    .data (act_data),
    .sat  (act_sat)
  );
endmodule

// File: tb/tb_neuron_acc.sv
// tb_neuron_acc: three DUTs (NUM_BEATS 4, 2, 1) checked against an arithmetic reference model
module tb_neuron_acc;
  logic        clk = 0, areset = 1;
  logic        iv[3], ir[3], ov[3], ord[3], os[3];
  logic [31:0] qq[3], bb[3], od[3];
  logic [31:0] qs[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    neuron_acc #(.DATA_W(32), .ACC_W(40), .NUM_BEATS(g == 0 ? 4 : g == 1 ? 2 : 1)) dut (
      .clk(clk), .areset(areset), .in_valid(iv[g]), .in_ready(ir[g]), .q(qq[g]), .bias(bb[g]),
      .out_valid(ov[g]), .out_ready(ord[g]), .out_data(od[g]), .out_sat(os[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [31:0] b);
    longint s;
    logic sat;
    logic [31:0] d;
    s = longint'($signed(b));
    foreach (qs[k]) s += longint'($signed(qs[k]));
    sat = s > 64'sd2147483647 || s < -64'sd2147483648;
    d = s > 64'sd2147483647 ? 32'h7FFF_FFFF : s < -64'sd2147483648 ? 32'h8000_0000 : s[31:0];
`ifdef NEURON_ACC_RELU_EN
    if (d[31]) d = '0;
`endif
    return {sat, d};
  endfunction
  task automatic run(input int i, input logic [31:0] b, input bit rdy, input int hold);
    logic [32:0] e;
    e = model(b);
    ord[i] = rdy;
    foreach (qs[k]) begin
      iv[i] = 1;
      qq[i] = qs[k];
      bb[i] = k == 0 ? b : $urandom;
      @(posedge clk); #1;
      if (k < qs.size() - 1) chk("mid_ov", ov[i], 0);
    end
    iv[i]  = 0;
    ord[i] = hold == 0;
    chk("res_ov", ov[i], 1);
    chk("res_ir", ir[i], 0);
    chk("res_data", od[i], e[31:0]);
    chk("res_sat", os[i], e[32]);
    for (int h = 0; h < hold; h++) begin
      iv[i] = 1;
      qq[i] = $urandom;
      @(posedge clk); #1;
      chk("hold_ir", ir[i], 0);
      chk("hold_data", od[i], e[31:0]);
      chk("hold_sat", os[i], e[32]);
    end
    iv[i]  = 0;
    ord[i] = 1;
    @(posedge clk); #1;
    chk("rel_ov", ov[i], 0);
    chk("rel_ir", ir[i], 1);
    ord[i] = 0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; ord[i] = 0; qq[i] = 0; bb[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ov", ov[i], 0);
      chk("rst_data", od[i], 0);
      chk("rst_sat", os[i], 0);
    end
    areset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("rst_ir", ir[i], 1);
    qs = '{1, 2, 3, 4};
    run(0, 10, 1, 0);
    qs = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run(1, 0, 0, 0);
    qs = '{10, 20, 5, 15};
    run(0, -100, 0, 0);
    qs = '{$urandom, $urandom_range(0, 99), 7, -3};
    run(0, $urandom_range(0, 999), 0, 5);
    qs = '{3, -8, 100, 2};
    run(0, -1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      iv[0] = 1; qq[0] = 1; bb[0] = 0;
      @(posedge clk); #1;
    end
    areset = 1;
    @(posedge clk); #1;
    chk("midrst_ov", ov[0], 0);
    chk("midrst_ir", ir[0], 1);
    areset = 0; iv[0] = 0;
    qs = '{1, 1, 1, 1};
    run(0, 0, 0, 0);
    qs = '{-3};
    run(2, 5, 0, 0);
    iv[2] = 1; qq[2] = 9; bb[2] = 9;
    @(posedge clk); #1;
    iv[2] = 0;
    chk("hold_pre_rst", ov[2], 1);
    areset = 1;
    @(posedge clk); #1;
    areset = 0;
    chk("holdrst_ov", ov[2], 0);
    chk("holdrst_data", od[2], 0);
    chk("holdrst_sat", os[2], 0);
    for (int n = 0; n < 60; n++) begin
      int i;
      int nb;
      i  = n % 3;
      nb = i == 0 ? 4 : i == 1 ? 2 : 1;
      qs = {};
      for (int k = 0; k < nb; k++)
        qs.push_back($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000);
      run(i, $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100,
          1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/neuron_acc.md
NEURON_ACC -- requirements
Module: neuron_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the incoming scalar-product word, bias and output.
REQ-002 SHALL have parameter ACC_W, default 40: internal accumulator width; legal range ACC_W > DATA_W.
REQ-003 SHALL have parameter NUM_BEATS, default 8: partial products per neuron; legal range 1 to 256.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: q and bias are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-008 SHALL have port q, input, DATA_W bits: signed two's-complement partial dot product from the scalar-product stage.
REQ-009 SHALL have port bias, input, DATA_W bits: signed neuron bias, sampled only on beat 0.
REQ-010 SHALL have port out_valid, output, 1 bit: a neuron result is held.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_data, output, DATA_W bits: signed activated neuron output.
REQ-013 SHALL have port out_sat, output, 1 bit: saturation occurred on this result.

Function
REQ-014 SHALL complete a beat transfer when in_valid and in_ready are both 1 on a rising edge, and a result transfer when out_valid and out_ready are both 1.
REQ-015 SHALL implement two states, ACC and HOLD: ACC drives in_ready=1 and out_valid=0; HOLD drives in_ready=0 and out_valid=1.
REQ-016 SHALL load acc = sext(bias) + sext(q) on a beat with beat count 0.
REQ-017 SHALL update acc = acc + sext(q) on any other accepted beat, and increment the beat count on every accepted beat.
REQ-018 SHALL, on the beat where count = NUM_BEATS-1, compute the final sum, register the result, clear the count and move to HOLD; out_valid rises the cycle after that beat.
REQ-019 SHALL, when NUM_BEATS=1, load bias+q and produce the result from the same beat.
REQ-020 SHALL saturate the final sum to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set out_sat=1 when clamped; no saturation occurs inside the ACC_W accumulator.
REQ-021 SHALL apply the activation defined in REQ-028/REQ-029 after saturation.
REQ-022 SHALL hold out_data and out_sat stable in HOLD until the transfer completes, then return to ACC on the next edge; this leaves one bubble cycle per neuron.
REQ-023 SHALL ignore in_valid in HOLD: no accumulation and no count change.
REQ-024 SHALL not let out_ready asserted in ACC affect state.

Reset
REQ-025 SHALL, with areset=1 at a rising edge, set state=ACC, count=0, acc=0, out_data=0, out_sat=0 and out_valid=0; in_ready=1 from the following cycle.
REQ-026 SHALL discard any partial sum or held result on reset mid-operation.
REQ-027 SHALL give reset priority over a simultaneous beat or result transfer.

Configuration
REQ-028 SHALL, with macro NEURON_ACC_RELU_EN defined, apply ReLU: a negative saturated value outputs 0, and out_sat still reflects the saturation.
REQ-029 SHALL, without NEURON_ACC_RELU_EN, output the saturated value unchanged (identity activation).

Structure
REQ-030 SHALL place the state enum (ACC, HOLD) and the default DATA_W/ACC_W constants in shared package ann_pkg.
REQ-031 SHALL implement saturation plus activation as combinational sub-module neuron_act, instantiated once.

Verification
REQ-032 Directed scenarios the bench SHALL cover:
- NUM_BEATS=4; bias=10; q=1,2,3,4 on consecutive cycles; out_ready=1 -> out_data=20, out_sat=0, out_valid one cycle after the 4th beat.
- NUM_BEATS=2; bias=0; q=0x7FFFFFFF twice -> out_data=0x7FFFFFFF, out_sat=1.
- bias=-100; q summing to 50 -> out_data=0 with RELU_EN, -50 without; out_sat=0.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> out_data stable, in_ready=0, next neuron sums exactly its own beats after release.
- areset pulsed after 2 of 4 beats -> out_valid=0; next 4 beats with bias=0, q=1 each -> out_data=4.
- NUM_BEATS=1; bias=5, q=-3 -> out_data=2.
